// File: rtl/tick_counter.sv
// Programmable prescaler tick generator driving an up/down/bounce/hold counter.
// Define TICK_COUNTER_BOUNCE_EN to build bounce mode; otherwise mode 2'b10 holds.
module tick_counter #(
    parameter int unsigned DIV_BITS = 25,
    parameter int unsigned WIDTH    = 4
) (
    input  logic                clkin,
    input  logic                rstn,
    input  logic                en,
    input  logic [DIV_BITS-1:0] div,
    input  logic [1:0]          mode,
    input  logic                saturate,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    output logic [WIDTH-1:0]    count,
    output logic                tick,
    output logic                wrap
);

    localparam logic [WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] CNT_ZERO  = '0;
    localparam logic [1:0]       MODE_UP   = 2'b00;
    localparam logic [1:0]       MODE_DOWN = 2'b01;

    logic [DIV_BITS-1:0] psc;
    logic [DIV_BITS-1:0] div_eff;
    logic [DIV_BITS-1:0] psc_last;
    logic                terminal;
    logic [WIDTH-1:0]    step_count;
    logic                step_wrap;

    // A divisor of zero behaves as one; >= keeps a shrinking divisor from overrunning.
    assign div_eff  = (div == '0) ? DIV_BITS'(1) : div;
    assign psc_last = div_eff - DIV_BITS'(1);
    assign terminal = en && (psc >= psc_last);

`ifdef TICK_COUNTER_BOUNCE_EN
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    logic             dir_down;
    logic             going_down;
    logic [WIDTH-1:0] bounce_count;
    logic             bounce_wrap;

    // Boundaries force the direction so entry at MAX heads down and at 0 heads up.
    always_comb begin
        going_down   = (count == CNT_MAX) || ((count != CNT_ZERO) && dir_down);
        bounce_count = going_down ? (count - WIDTH'(1)) : (count + WIDTH'(1));
        bounce_wrap  = going_down ? (bounce_count == CNT_ZERO)
                                  : (bounce_count == CNT_MAX);
    end

    // Direction returns to up whenever another mode steps, so re-entry resumes upward.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            dir_down <= 1'b0;
        end else if (load) begin
            dir_down <= 1'b0;
        end else if (terminal) begin
            if (mode == MODE_BOUNCE) begin
                dir_down <= going_down ^ bounce_wrap;
            end else begin
                dir_down <= 1'b0;
            end
        end
    end
`endif

    // Value and wrap flag the counter takes on the next terminal edge.
    always_comb begin
        step_count = count;
        step_wrap  = 1'b0;
        case (mode)
            MODE_UP: begin
                if (count == CNT_MAX) begin
                    step_wrap  = 1'b1;
                    step_count = saturate ? CNT_MAX : CNT_ZERO;
                end else begin
                    step_count = count + WIDTH'(1);
                end
            end
            MODE_DOWN: begin
                if (count == CNT_ZERO) begin
                    step_wrap  = 1'b1;
                    step_count = saturate ? CNT_ZERO : CNT_MAX;
                end else begin
                    step_count = count - WIDTH'(1);
                end
            end
`ifdef TICK_COUNTER_BOUNCE_EN
            MODE_BOUNCE: begin
                step_count = bounce_count;
                step_wrap  = bounce_wrap;
            end
`endif
            default: begin
                step_count = count;
                step_wrap  = 1'b0;
            end
        endcase
    end

    // Prescaler, counter and pulse outputs; load outranks everything but reset.
    always_ff @(posedge clkin or negedge rstn) begin
        if (!rstn) begin
            psc   <= '0;
            count <= '0;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (load) begin
            psc   <= '0;
            count <= load_val;
            tick  <= 1'b0;
            wrap  <= 1'b0;
        end else if (terminal) begin
            psc   <= '0;
            count <= step_count;
            tick  <= 1'b1;
            wrap  <= step_wrap;
        end else begin
            if (en) begin
                psc <= psc + DIV_BITS'(1);
            end
            tick <= 1'b0;
            wrap <= 1'b0;
        end
    end

endmodule
